// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC engine: arctangent table,
// gain-correction constant and the operating-mode encodings.
package cordic_pkg;

  typedef enum logic {
    MODE_ROTATE = 1'b0,
    MODE_VECTOR = 1'b1
  } cordic_mode_e;

  // atan(2^-i) expressed as a 32-bit binary angle (2^32 == 2*pi).
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // 1/An = 0.6072529350 scaled by 2^31.
  localparam logic [31:0] K_GAIN_32 = 32'h4DBA76D4;

  // Keep the upper 'width' bits of a 32-bit constant, rounding half-up
  // on the first discarded bit.
  function automatic logic [31:0] scale_const(input logic [31:0] c32,
                                              input int width);
    logic [32:0] tmp;
    if (width >= 32) begin
      return c32;
    end
    tmp = {1'b0, c32} + (33'd1 << (31 - width));
    return 32'(tmp >> (32 - width));
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation stage: picks a direction from the current
// angle (rotation) or y sign (vectoring), applies the shift-add rotation and
// registers the result together with its valid and mode bits.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STAGE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic                    valid,
  input  logic                    mode,
  input  logic signed [WIDTH+1:0] x,
  input  logic signed [WIDTH+1:0] y,
  input  logic        [WIDTH-1:0] z,
  output logic                    rot_valid,
  output logic                    rot_mode,
  output logic signed [WIDTH+1:0] rot_x,
  output logic signed [WIDTH+1:0] rot_y,
  output logic        [WIDTH-1:0] rot_z
);

  localparam logic [WIDTH-1:0] ATAN_I = WIDTH'(scale_const(ATAN_TABLE[STAGE], WIDTH));

  logic                    dir_pos;
  logic signed [WIDTH+1:0] x_shift;
  logic signed [WIDTH+1:0] y_shift;
  logic signed [WIDTH+1:0] x_new;
  logic signed [WIDTH+1:0] y_new;
  logic        [WIDTH-1:0] z_new;

  // Choose the rotation direction and form the micro-rotated vector and angle
  always_comb begin
    x_shift = x >>> STAGE;
    y_shift = y >>> STAGE;
    dir_pos = 1'b0;
    x_new   = x;
    y_new   = y;
    z_new   = z;
    if (mode == MODE_VECTOR) begin
      dir_pos = y[WIDTH+1];
    end else begin
      dir_pos = ~z[WIDTH-1];
    end
    if (dir_pos) begin
      x_new = x - y_shift;
      y_new = y + x_shift;
      z_new = z - ATAN_I;
    end else begin
      x_new = x + y_shift;
      y_new = y - x_shift;
      z_new = z + ATAN_I;
    end
  end

  // Pipeline register for this stage; moves only when the whole pipe advances
  always_ff @(posedge clk) begin
    if (!rst) begin
      rot_valid <= 1'b0;
      rot_mode  <= 1'b0;
      rot_x     <= '0;
      rot_y     <= '0;
      rot_z     <= '0;
    end else if (advance) begin
      rot_valid <= valid;
      rot_mode  <= mode;
      rot_x     <= x_new;
      rot_y     <= y_new;
      rot_z     <= z_new;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Fully pipelined CORDIC engine: a pre-rotation stage folding the input into
// the convergence range, ITER micro-rotation stages, and a gain-compensation
// stage with half-up rounding and saturation. The whole pipe stalls together
// when the output is held by back-pressure.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             out_mode
);

  localparam int XW = WIDTH + 2;
  localparam int PW = XW + WIDTH + 1;

  localparam logic        [WIDTH-1:0] HALF_TURN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0]   K_GAIN     = (WIDTH+1)'(scale_const(K_GAIN_32, WIDTH));
  localparam logic signed [PW-1:0]    ROUND_HALF = {{(PW-1){1'b0}}, 1'b1} << (WIDTH - 2);
  localparam logic signed [WIDTH-1:0] SAT_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  logic advance;

  logic                 flip;
  logic signed [XW-1:0] ext_x;
  logic signed [XW-1:0] ext_y;
  logic signed [XW-1:0] pre_x_c;
  logic signed [XW-1:0] pre_y_c;
  logic    [WIDTH-1:0]  pre_z_c;

  logic                 pre_valid;
  logic                 pre_mode;
  logic signed [XW-1:0] pre_x;
  logic signed [XW-1:0] pre_y;
  logic    [WIDTH-1:0]  pre_z;

  logic                 stg_valid [ITER+1];
  logic                 stg_mode  [ITER+1];
  logic signed [XW-1:0] stg_x     [ITER+1];
  logic signed [XW-1:0] stg_y     [ITER+1];
  logic    [WIDTH-1:0]  stg_z     [ITER+1];

  logic [WIDTH-1:0] comp_x;
  logic [WIDTH-1:0] comp_y;

  // Multiply by the gain correction, round half-up, saturate to WIDTH bits.
  function automatic logic [WIDTH-1:0] gain_comp(input logic signed [XW-1:0] v);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rounded;
    prod    = PW'(v) * PW'(K_GAIN);
    rounded = (prod + ROUND_HALF) >>> (WIDTH - 1);
    if (rounded > PW'(SAT_MAX)) begin
      gain_comp = SAT_MAX;
    end else if (rounded < PW'(SAT_MIN)) begin
      gain_comp = SAT_MIN;
    end else begin
      gain_comp = rounded[WIDTH-1:0];
    end
  endfunction

  // A stalled output freezes every stage at once, so bubbles keep their slots.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Fold the input into +-pi/2 by a half-turn when it lies outside that range
  always_comb begin
    ext_x   = {{2{in_x[WIDTH-1]}}, in_x};
    ext_y   = {{2{in_y[WIDTH-1]}}, in_y};
    flip    = 1'b0;
    pre_x_c = ext_x;
    pre_y_c = ext_y;
    pre_z_c = in_z;
    if (in_mode == MODE_VECTOR) begin
      flip = in_x[WIDTH-1];
    end else begin
      flip = in_z[WIDTH-1] ^ in_z[WIDTH-2];
    end
    if (flip) begin
      pre_x_c = -ext_x;
      pre_y_c = -ext_y;
      pre_z_c = in_z + HALF_TURN;
    end
  end

  // Pre-rotation register, loaded on every advancing cycle (bubble or sample)
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_valid <= 1'b0;
      pre_mode  <= 1'b0;
      pre_x     <= '0;
      pre_y     <= '0;
      pre_z     <= '0;
    end else if (advance) begin
      pre_valid <= in_valid;
      pre_mode  <= in_mode;
      pre_x     <= pre_x_c;
      pre_y     <= pre_y_c;
      pre_z     <= pre_z_c;
    end
  end

  assign stg_valid[0] = pre_valid;
  assign stg_mode[0]  = pre_mode;
  assign stg_x[0]     = pre_x;
  assign stg_y[0]     = pre_y;
  assign stg_z[0]     = pre_z;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_stage #(
      .WIDTH (WIDTH),
      .STAGE (i)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .valid     (stg_valid[i]),
      .mode      (stg_mode[i]),
      .x         (stg_x[i]),
      .y         (stg_y[i]),
      .z         (stg_z[i]),
      .rot_valid (stg_valid[i+1]),
      .rot_mode  (stg_mode[i+1]),
      .rot_x     (stg_x[i+1]),
      .rot_y     (stg_y[i+1]),
      .rot_z     (stg_z[i+1])
    );
  end

  // Undo the accumulated CORDIC gain on the final vector
  always_comb begin
    comp_x = gain_comp(stg_x[ITER]);
    comp_y = gain_comp(stg_y[ITER]);
  end

  // Output register; holds its contents while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (advance) begin
      out_valid <= stg_valid[ITER];
      out_mode  <= stg_mode[ITER];
      out_x     <= comp_x;
      out_y     <= comp_y;
      out_z     <= stg_z[ITER];
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine at WIDTH=16, ITER=16. Expected values
// come from a floating-point rotation/vectoring model with small tolerances.
module tb_cordic_engine;

  localparam int  WIDTH     = 16;
  localparam int  ITER      = 16;
  localparam int  LAT       = ITER + 2;
  localparam real PI        = 3.14159265358979323846;
  localparam real ANG_SCALE = 65536.0 / (2.0 * PI);
  localparam real ONE       = 16384.0;
  localparam int  TOL_SPEC  = 2;
  localparam int  TOL_XY    = 6;
  localparam int  TOL_Z     = 8;

  typedef struct {
    int x;
    int y;
    int z;
    int mode;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [WIDTH-1:0] in_z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [WIDTH-1:0] out_z;
  logic             out_mode;

  int total = 0;
  int bad   = 0;

  cordic_engine #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_mode  (out_mode)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  function automatic int rnd(input real v);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wrap_ang(input int v);
    int w;
    w = v & 32'h0000FFFF;
    if (w >= 32768) w = w - 65536;
    return w;
  endfunction

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ang_err(input int a, input int e);
    return abs_i(wrap_ang(a - e));
  endfunction

  // Ideal result: rotate (x,y) by z, or find magnitude and z + atan2(y,x).
  function automatic res_t ref_model(input int mode, input int x, input int y, input int z);
    res_t r;
    real  th;
    real  fx;
    real  fy;
    fx = x;
    fy = y;
    if (mode == 0) begin
      th  = z / ANG_SCALE;
      r.x = sat(rnd(fx * $cos(th) - fy * $sin(th)));
      r.y = sat(rnd(fx * $sin(th) + fy * $cos(th)));
      r.z = 0;
    end else begin
      r.x = sat(rnd($sqrt(fx * fx + fy * fy)));
      r.y = 0;
      r.z = wrap_ang(z + rnd($atan2(fy, fx) * ANG_SCALE));
    end
    r.mode = mode;
    return r;
  endfunction

  // Random input with magnitude 0.5..1.4 so results never saturate.
  function automatic res_t gen_sample();
    res_t s;
    real  r;
    real  a;
    r      = 0.5 + 0.9 * real'($urandom_range(0, 1000)) / 1000.0;
    a      = 2.0 * PI * real'($urandom_range(0, 65535)) / 65536.0;
    s.x    = rnd(r * ONE * $cos(a));
    s.y    = rnd(r * ONE * $sin(a));
    s.z    = int'($urandom_range(0, 65535)) - 32768;
    s.mode = int'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_z     = '0;
  endtask

  task automatic drive_sample(input res_t s);
    in_valid = 1'b1;
    in_mode  = s.mode[0];
    in_x     = s.x[WIDTH-1:0];
    in_y     = s.y[WIDTH-1:0];
    in_z     = s.z[WIDTH-1:0];
  endtask

  // Push one sample through an empty pipe and collect its result and latency.
  task automatic run_single(input int mode, input int x, input int y, input int z,
                            output res_t res, output int cycles,
                            output bit timed_out, output bit has_x);
    res_t s;
    int   guard;
    s.mode = mode; s.x = x; s.y = y; s.z = z;
    timed_out = 1'b0;
    cycles    = 0;
    guard     = 0;
    @(negedge clk);
    out_ready = 1'b1;
    drive_sample(s);
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) timed_out = 1'b1;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    drive_idle();
    while (out_valid !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    if (out_valid !== 1'b1) timed_out = 1'b1;
    has_x    = $isunknown({out_x, out_y, out_z, out_mode});
    res.x    = int'($signed(out_x));
    res.y    = int'($signed(out_y));
    res.z    = int'($signed(out_z));
    res.mode = int'(out_mode);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    out_ready = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_x !== 16'h0000) begin bad++; $display("[TB] FAIL reset_out_x: got %h want 0000", out_x); end
    total++; if (out_y !== 16'h0000) begin bad++; $display("[TB] FAIL reset_out_y: got %h want 0000", out_y); end
    total++; if (out_z !== 16'h0000) begin bad++; $display("[TB] FAIL reset_out_z: got %h want 0000", out_z); end
    total++; if (out_mode !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_mode: got %b want 0", out_mode); end
    rst = 1'b1;
  endtask

  task automatic test_rotation_pi4();
    res_t r; int cyc; bit to; bit hx;
    run_single(0, 16384, 0, 8192, r, cyc, to, hx);
    total++; if (to || hx) begin bad++; $display("[TB] FAIL pi4_done: timeout=%0d unknown=%0d want 0 0", to, hx); end
    total++; if (cyc != LAT) begin bad++; $display("[TB] FAIL pi4_latency: got %0d want %0d", cyc, LAT); end
    total++; if (abs_i(r.x - 11585) > TOL_SPEC) begin bad++; $display("[TB] FAIL pi4_x: got %0d want 11585", r.x); end
    total++; if (abs_i(r.y - 11585) > TOL_SPEC) begin bad++; $display("[TB] FAIL pi4_y: got %0d want 11585", r.y); end
    total++; if (ang_err(r.z, 0) > TOL_SPEC) begin bad++; $display("[TB] FAIL pi4_z: got %0d want 0", r.z); end
    total++; if (r.mode != 0) begin bad++; $display("[TB] FAIL pi4_mode: got %0d want 0", r.mode); end
  endtask

  task automatic test_rotation_neg_pi();
    res_t r; int cyc; bit to; bit hx;
    run_single(0, 16384, 0, -32768, r, cyc, to, hx);
    total++; if (to || hx) begin bad++; $display("[TB] FAIL negpi_done: timeout=%0d unknown=%0d want 0 0", to, hx); end
    total++; if (abs_i(r.x + 16384) > TOL_SPEC) begin bad++; $display("[TB] FAIL negpi_x: got %0d want -16384", r.x); end
    total++; if (abs_i(r.y) > TOL_SPEC) begin bad++; $display("[TB] FAIL negpi_y: got %0d want 0", r.y); end
  endtask

  task automatic test_vector_34();
    res_t r; int cyc; bit to; bit hx;
    run_single(1, 12288, 16384, 0, r, cyc, to, hx);
    total++; if (to || hx) begin bad++; $display("[TB] FAIL vec34_done: timeout=%0d unknown=%0d want 0 0", to, hx); end
    total++; if (abs_i(r.x - 20480) > TOL_SPEC) begin bad++; $display("[TB] FAIL vec34_x: got %0d want 20480", r.x); end
    total++; if (abs_i(r.y) > TOL_SPEC) begin bad++; $display("[TB] FAIL vec34_y: got %0d want 0", r.y); end
    total++; if (ang_err(r.z, 9672) > TOL_SPEC) begin bad++; $display("[TB] FAIL vec34_z: got %0d want 9672", r.z); end
    total++; if (r.mode != 1) begin bad++; $display("[TB] FAIL vec34_mode: got %0d want 1", r.mode); end
  endtask

  task automatic test_vector_neg_axis();
    res_t r; int cyc; bit to; bit hx;
    run_single(1, -16384, 0, 0, r, cyc, to, hx);
    total++; if (to || hx) begin bad++; $display("[TB] FAIL negaxis_done: timeout=%0d unknown=%0d want 0 0", to, hx); end
    total++; if (abs_i(r.x - 16384) > TOL_SPEC) begin bad++; $display("[TB] FAIL negaxis_x: got %0d want 16384", r.x); end
    total++; if (ang_err(r.z, -32768) > TOL_SPEC) begin bad++; $display("[TB] FAIL negaxis_z: got %0d want -32768", r.z); end
  endtask

  task automatic test_zero_input();
    res_t r; int cyc; bit to; bit hx; int zsum;
    zsum = 0;
    for (int i = 0; i < ITER; i++) zsum += rnd($atan($pow(2.0, -i)) * ANG_SCALE);
    zsum = wrap_ang(zsum);
    run_single(1, 0, 0, 0, r, cyc, to, hx);
    total++; if (to || hx) begin bad++; $display("[TB] FAIL zero_vec_done: timeout=%0d unknown=%0d want 0 0", to, hx); end
    total++; if (r.x != 0 || r.y != 0) begin bad++; $display("[TB] FAIL zero_vec_xy: got %0d,%0d want 0,0", r.x, r.y); end
    total++; if (r.z != zsum) begin bad++; $display("[TB] FAIL zero_vec_z: got %0d want %0d", r.z, zsum); end
    run_single(0, 0, 0, 0, r, cyc, to, hx);
    total++; if (to || hx) begin bad++; $display("[TB] FAIL zero_rot_done: timeout=%0d unknown=%0d want 0 0", to, hx); end
    total++; if (r.x != 0 || r.y != 0) begin bad++; $display("[TB] FAIL zero_rot_xy: got %0d,%0d want 0,0", r.x, r.y); end
  endtask

  // Random stream with random back-pressure; every valid output cycle must
  // show the oldest outstanding expected result.
  task automatic test_random();
    localparam int N = 60;
    res_t samp[$]; res_t exp_q[$]; res_t e;
    int sent; int got; int cyc;
    for (int k = 0; k < N; k++) samp.push_back(gen_sample());
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < 3000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      if (sent < N) drive_sample(samp[sent]); else drive_idle();
      #1;
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL rand_spurious: got out_valid=1 want 0 at cycle %0d", cyc);
        end else begin
          e = exp_q[0];
          if (abs_i(int'($signed(out_x)) - e.x) > TOL_XY || abs_i(int'($signed(out_y)) - e.y) > TOL_XY ||
              ang_err(int'($signed(out_z)), e.z) > TOL_Z || int'(out_mode) != e.mode) begin
            bad++;
            $display("[TB] FAIL rand_result[%0d]: got x=%0d y=%0d z=%0d m=%0d want x=%0d y=%0d z=%0d m=%0d",
                     got, $signed(out_x), $signed(out_y), $signed(out_z), out_mode, e.x, e.y, e.z, e.mode);
          end
          if (out_ready) begin void'(exp_q.pop_front()); got++; end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(samp[sent].mode, samp[sent].x, samp[sent].y, samp[sent].z));
        sent++;
      end
      cyc++;
    end
    drive_idle();
    total++;
    if (got != N || exp_q.size() != 0) begin
      bad++; $display("[TB] FAIL rand_count: got %0d outputs (%0d pending) want %0d", got, exp_q.size(), N);
    end
  endtask

  // 20 back-to-back samples with out_ready toggling 1,0,1,0...
  task automatic test_back_to_back();
    localparam int N = 20;
    res_t samp[$]; res_t exp_q[$]; res_t e;
    int sent; int got; int cyc;
    for (int k = 0; k < N; k++) samp.push_back(gen_sample());
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < 1000) begin
      @(negedge clk);
      out_ready = (cyc % 2 == 0);
      if (sent < N) drive_sample(samp[sent]); else drive_idle();
      #1;
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL b2b_spurious: got out_valid=1 want 0 at cycle %0d", cyc);
        end else begin
          e = exp_q[0];
          if (abs_i(int'($signed(out_x)) - e.x) > TOL_XY || abs_i(int'($signed(out_y)) - e.y) > TOL_XY ||
              ang_err(int'($signed(out_z)), e.z) > TOL_Z || int'(out_mode) != e.mode) begin
            bad++;
            $display("[TB] FAIL b2b_result[%0d]: got x=%0d y=%0d z=%0d m=%0d want x=%0d y=%0d z=%0d m=%0d",
                     got, $signed(out_x), $signed(out_y), $signed(out_z), out_mode, e.x, e.y, e.z, e.mode);
          end
          if (out_ready) begin void'(exp_q.pop_front()); got++; end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(samp[sent].mode, samp[sent].x, samp[sent].y, samp[sent].z));
        sent++;
      end
      cyc++;
    end
    drive_idle();
    total++;
    if (got != N || exp_q.size() != 0) begin
      bad++; $display("[TB] FAIL b2b_count: got %0d outputs (%0d pending) want %0d", got, exp_q.size(), N);
    end
  endtask

  // Ten samples in flight, one reset cycle, then nothing may ever come out.
  task automatic test_reset_midstream();
    int emitted;
    emitted = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive_sample(gen_sample());
    end
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid: got %b want 0", out_valid); end
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) emitted++;
    end
    total++;
    if (emitted != 0) begin bad++; $display("[TB] FAIL midreset_leak: got %0d outputs want 0", emitted); end
  endtask

  // Run every scenario in sequence and report
  initial begin
    rst       = 1'b0;
    out_ready = 1'b0;
    drive_idle();
    test_reset();
    test_rotation_pi4();
    test_rotation_neg_pi();
    test_vector_34();
    test_vector_neg_axis();
    test_zero_input();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_engine.md
CORDIC_ENGINE -- requirements
Module: cordic_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data/angle width in bits, legal range 8..32.
REQ-002 SHALL have parameter ITER, default 16, number of micro-rotation stages, legal range 4..WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: input sample present.
REQ-006 SHALL have port in_ready, output, 1 bit: engine accepts the sample this cycle.
REQ-007 SHALL have port in_mode, input, 1 bit: 0 = rotation, 1 = vectoring.
REQ-008 SHALL have ports in_x and in_y, input, WIDTH bits each: signed Q2.(WIDTH-2) coordinates, where 1.0 = 2^(WIDTH-2).
REQ-009 SHALL have port in_z, input, WIDTH bits: signed binary angle, where 2^WIDTH = 2*pi (0x4000 = pi/2 at WIDTH=16).
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have ports out_x, out_y and out_z, output, WIDTH bits each, in the same formats as the inputs.
REQ-013 SHALL have port out_mode, output, 1 bit: in_mode carried alongside its sample.

Function
REQ-014 SHALL implement ITER+2 register stages: one pre-rotation stage, ITER micro-rotation stages, and one gain-compensation stage.
REQ-015 SHALL give a fixed latency of ITER+2 cycles from input handshake to out_valid when there is no stall.
REQ-016 SHALL define a global advance = !out_valid || out_ready; in_ready = advance; all stages and their valid bits shift only when advance = 1.
REQ-017 SHALL accept a sample when in_valid and in_ready are both 1; bubbles propagate and are not compressed.
REQ-018 SHALL hold out_x, out_y, out_z and out_mode stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL pre-rotate in rotation mode: when in_z[MSB] differs from in_z[MSB-1] (|z| > pi/2), x and y are negated and z is replaced by z + 2^(WIDTH-1) (i.e. + pi), modulo 2^WIDTH.
REQ-020 SHALL pre-rotate in vectoring mode: when in_x < 0, x and y are negated and z is replaced by z + 2^(WIDTH-1).
REQ-021 SHALL carry x and y internally at WIDTH+2 bits (sign-extended guard bits); z is carried at WIDTH bits with wrap-around arithmetic.
REQ-022 SHALL set the stage-i direction d = +1 when z >= 0 in rotation mode, and d = +1 when y < 0 in vectoring mode; otherwise d = -1.
REQ-023 SHALL compute each stage i as: x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i.
REQ-024 SHALL use arithmetic (sign-preserving) right shifts only.
REQ-025 SHALL define atan_i = round(atan(2^-i) * 2^WIDTH / (2*pi)).
REQ-026 SHALL compensate gain by multiplying x and y by K = round(0.6072529350 * 2^(WIDTH-1)).
REQ-027 SHALL round the compensated product half-up and then saturate it to the signed WIDTH range.
REQ-028 SHALL pass z through the gain-compensation stage unchanged.
REQ-029 SHALL produce in rotation mode: (x, y) rotated by z; out_z = residual angle, within a few LSB of 0.
REQ-030 SHALL produce in vectoring mode: out_x = magnitude, out_y within a few LSB of 0, out_z = in_z + atan2(in_y, in_x).
REQ-031 SHALL handle the input in_x = in_y = 0: outputs are 0, 0, and z wraps per the stage arithmetic; no X is produced.

Reset
REQ-032 SHALL clear all stage valid bits to 0 while rst = 0, so that out_valid = 0 on the cycle after rst is sampled low.
REQ-033 SHALL reset out_x, out_y, out_z and out_mode to 0.
REQ-034 SHALL drive in_ready = 1 while out_valid = 0, including during reset.
REQ-035 SHALL discard in-flight samples when reset is asserted mid-stream; they are never emitted.

Structure
REQ-036 SHALL place the following in shared package cordic_pkg: the 32-entry atan table of 32-bit binary-angle constants (stage values taken from the upper WIDTH bits, rounded), the K constant at 32 bits, and the mode encodings.
REQ-037 SHALL implement one micro-rotation stage as sub-module cordic_stage, parameterised by WIDTH and stage index, and instantiated ITER times through a generate loop.

Verification (WIDTH=16, ITER=16, tolerance ±2 LSB)
REQ-038 SHALL verify rotation at pi/4: x=0x4000, y=0, z=0x2000 -> out_x = out_y = 0x2D41 after exactly 18 cycles.
REQ-039 SHALL verify rotation at -pi: x=0x4000, y=0, z=0x8000 -> out_x = 0xC000, out_y = 0x0000, exercising the pre-rotation stage.
REQ-040 SHALL verify vectoring of (0.75, 1.0): x=0x3000, y=0x4000, z=0 -> out_x = 0x5000, out_y = 0, out_z = 0x25C8.
REQ-041 SHALL verify vectoring on the negative axis: x=0xC000, y=0 -> out_x = 0x4000, out_z = 0x8000.
REQ-042 SHALL verify back-pressure: 20 back-to-back samples with out_ready toggling 1,0,1,0… -> all 20 emitted in order, no loss or duplication, outputs stable while stalled.
REQ-043 SHALL verify reset mid-stream: rst low for 1 cycle with 10 samples in flight -> out_valid = 0 the next cycle and none of the 10 samples is ever emitted.
